// File: rtl/pll_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pll_ctrl_pkg: shared types and helpers for the PLL reconfiguration control.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pll_ctrl_pkg;

  localparam int DIV_W = 6;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_IDLE      = 2'd2,
    ST_ERROR     = 2'd3
  } pll_state_e;

  // PLLVR samples FBDSEL/IDSEL active-low, so the natural value is inverted.
  function automatic logic [DIV_W-1:0] div_enc(input logic [DIV_W-1:0] v);
    return ~v;
  endfunction

  // Counter width for a limit of n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reconfig_ctrl_sync2.sv
// ----------------------------------------------------------------------------
// sync2: two-flop synchroniser, asynchronously cleared to 0.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reconfig_ctrl.sv
// ----------------------------------------------------------------------------
// pll_reconfig_ctrl: sequences PLLVR divider changes (reset, release, relock).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int INIT_FDIV    = 12,
  parameter int INIT_IDIV    = 5,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [DIV_W-1:0]                  req_fdiv,
  input  logic [DIV_W-1:0]                  req_idiv,
  input  logic                              pll_lock,
  output logic                              pll_reset,
  output logic [DIV_W-1:0]                  fdiv,
  output logic [DIV_W-1:0]                  idiv,
  output logic                              locked,
  output logic                              busy,
  output logic                              err,
  output logic [cnt_w(MAX_RETRY+1)-1:0]     retry_cnt
);

  localparam int RST_W = cnt_w(RESET_CYCLES);
  localparam int STB_W = cnt_w(LOCK_STABLE);
  localparam int TO_W  = cnt_w(LOCK_TIMEOUT);
  localparam int RTY_W = cnt_w(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [DIV_W-1:0] FDIV_INIT = div_enc(DIV_W'(INIT_FDIV));
  localparam logic [DIV_W-1:0] IDIV_INIT = div_enc(DIV_W'(INIT_IDIV));

  pll_state_e       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [DIV_W-1:0] fdiv_q, fdiv_d;
  logic [DIV_W-1:0] idiv_q, idiv_d;
  logic             pll_reset_q, pll_reset_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             lock_s;
  logic             accept;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = '0;
    stb_cnt_d   = '0;
    to_cnt_d    = '0;
    retry_d     = retry_q;
    fdiv_d      = fdiv_q;
    idiv_d      = idiv_q;
    pll_reset_d = pll_reset_q;
    locked_d    = locked_q;
    err_d       = err_q;
    ready_d     = ready_q;
    busy_d      = busy_q;

    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d     = ST_WAIT_LOCK;
          pll_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock completion is checked first so it wins a same-cycle timeout.
        if (lock_s && (stb_cnt_q == STB_LAST)) begin
          state_d  = ST_IDLE;
          locked_d = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          retry_d  = '0;
        end else if (to_cnt_q == TO_LAST) begin
          if (retry_q < RTY_MAX) begin
            state_d     = ST_RESET;
            pll_reset_d = 1'b1;
            retry_d     = retry_q + 1'b1;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          to_cnt_d  = to_cnt_q + 1'b1;
          stb_cnt_d = lock_s ? (stb_cnt_q + 1'b1) : '0;
        end
      end
      ST_IDLE: begin
        if (!lock_s) begin
          state_d     = ST_RESET;
          pll_reset_d = 1'b1;
          locked_d    = 1'b0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
          retry_d     = '0;
        end
      end
      default: begin
      end
    endcase

    // An accepted request overrides any lock-loss decision made above.
    if (accept) begin
      state_d     = ST_RESET;
      rst_cnt_d   = '0;
      fdiv_d      = div_enc(req_fdiv);
      idiv_d      = div_enc(req_idiv);
      pll_reset_d = 1'b1;
      locked_d    = 1'b0;
      err_d       = 1'b0;
      retry_d     = '0;
      ready_d     = 1'b0;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      to_cnt_q    <= '0;
      retry_q     <= '0;
      fdiv_q      <= FDIV_INIT;
      idiv_q      <= IDIV_INIT;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      to_cnt_q    <= to_cnt_d;
      retry_q     <= retry_d;
      fdiv_q      <= fdiv_d;
      idiv_q      <= idiv_d;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign pll_reset = pll_reset_q;
  assign fdiv      = fdiv_q;
  assign idiv      = idiv_q;
  assign locked    = locked_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pll_reconfig_ctrl: directed stimulus with a cycle-level reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pll_reconfig_ctrl;

  localparam int RC = 16;
  localparam int LS = 64;
  localparam int LT = 256;
  localparam int MR = 3;
  localparam logic [5:0] INIT_F = 6'd12;
  localparam logic [5:0] INIT_I = 6'd5;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_fdiv  = 6'd0;
  logic [5:0] req_idiv  = 6'd0;
  logic       pll_lock  = 1'b0;
  logic       req_ready;
  logic       pll_reset;
  logic [5:0] fdiv;
  logic [5:0] idiv;
  logic       locked;
  logic       busy;
  logic       err;
  logic [1:0] retry_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pll_reconfig_ctrl #(
    .INIT_FDIV    (12),
    .INIT_IDIV    (5),
    .RESET_CYCLES (RC),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRY    (MR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fdiv  (req_fdiv),
    .req_idiv  (req_idiv),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .fdiv      (fdiv),
    .idiv      (idiv),
    .locked    (locked),
    .busy      (busy),
    .err       (err),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a sequence is "seeking" for m_t elapsed cycles; the first RC
  // of them hold the PLL in reset, the remainder are the lock wait window.
  localparam int M_SEEK = 0;
  localparam int M_IDLE = 1;
  localparam int M_ERR  = 2;

  int         m_mode  = M_SEEK;
  int         m_t     = 0;
  int         m_run   = 0;
  int         m_tries = 0;
  logic [5:0] m_fd    = INIT_F;
  logic [5:0] m_id    = INIT_I;
  logic       s1      = 1'b0;
  logic       s2      = 1'b0;
  wire        m_acc   = req_valid && (m_mode != M_SEEK);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= M_SEEK;
      m_t     <= 0;
      m_run   <= 0;
      m_tries <= 0;
      m_fd    <= INIT_F;
      m_id    <= INIT_I;
      s1      <= 1'b0;
      s2      <= 1'b0;
    end else begin
      s1 <= pll_lock;
      s2 <= s1;
      if (m_acc) begin
        m_fd    <= req_fdiv;
        m_id    <= req_idiv;
        m_mode  <= M_SEEK;
        m_t     <= 0;
        m_run   <= 0;
        m_tries <= 0;
      end else begin
        case (m_mode)
          M_SEEK: begin
            if (m_t < RC) begin
              m_t   <= m_t + 1;
              m_run <= 0;
            end else if (s2 && (m_run + 1 == LS)) begin
              m_mode  <= M_IDLE;
              m_tries <= 0;
            end else if (m_t - RC == LT - 1) begin
              if (m_tries < MR) begin
                m_tries <= m_tries + 1;
                m_t     <= 0;
                m_run   <= 0;
              end else begin
                m_mode <= M_ERR;
              end
            end else begin
              m_t   <= m_t + 1;
              m_run <= s2 ? m_run + 1 : 0;
            end
          end
          M_IDLE: begin
            if (!s2) begin
              m_mode  <= M_SEEK;
              m_t     <= 0;
              m_run   <= 0;
              m_tries <= 0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [18:0] act;
    logic [18:0] exp;
    logic        e_seek;
    forever begin
      @(negedge clk);
      e_seek = (m_mode == M_SEEK);
      exp = {e_seek && (m_t < RC), m_mode == M_IDLE, e_seek, m_mode == M_ERR,
             !e_seek, 2'(m_tries), ~m_fd, ~m_id};
      act = {pll_reset, locked, busy, err, req_ready, retry_cnt, fdiv, idiv};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, act, exp);
      end
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return pll_reset;
      1:       return locked;
      default: return err;
    endcase
  endfunction

  // Counts rising clk edges until the selected output equals v (bounded).
  task automatic count_until(input int w, input logic v, input int lim, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((sel(w) !== v) && (n < lim));
  endtask

  task automatic main_seq();
    int n;
    int pulses;
    int seq;
    logic prev_rst;
    logic [1:0] prev_rty;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pll_reset", int'(pll_reset), 1);
    chk("rst_fdiv", int'(fdiv), int'(6'b110011));
    chk("rst_idiv", int'(idiv), int'(6'b111010));
    chk("rst_locked", int'(locked), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_err", int'(err), 0);

    // Power-up: lock arrives 100 cycles after release
    rst_n = 1'b1;
    count_until(0, 1'b0, 100, n);
    chk("pwrup_reset_cycles", n, 16);
    repeat (84) @(posedge clk);
    #2 pll_lock = 1'b1;
    count_until(1, 1'b1, 300, n);
    chk("pwrup_lock_latency", n, 66);
    chk("pwrup_ready", int'(req_ready), 1);
    chk("pwrup_busy", int'(busy), 0);

    // Reconfiguration to fdiv=20, idiv=3
    #1;
    req_valid = 1'b1;
    req_fdiv  = 6'd20;
    req_idiv  = 6'd3;
    @(posedge clk);
    #1;
    chk("reconf_fdiv", int'(fdiv), int'(6'b101011));
    chk("reconf_idiv", int'(idiv), int'(6'b111100));
    chk("reconf_pll_reset", int'(pll_reset), 1);
    chk("reconf_locked", int'(locked), 0);
    chk("reconf_ready", int'(req_ready), 0);
    #1 req_valid = 1'b0;
    count_until(0, 1'b0, 100, n);
    chk("reconf_reset_cycles", n, 16);
    count_until(1, 1'b1, 300, n);
    chk("reconf_relock", n, 64);

    // Request lands on the same edge that sees the lock loss
    #1 pll_lock = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("race_still_locked", int'(locked), 1);
    req_valid = 1'b1;
    req_fdiv  = 6'd7;
    req_idiv  = 6'd2;
    @(posedge clk);
    #1;
    chk("race_fdiv", int'(fdiv), int'(6'b111000));
    chk("race_idiv", int'(idiv), int'(6'b111101));
    chk("race_pll_reset", int'(pll_reset), 1);
    #1 req_valid = 1'b0;

    // Lock glitch during WAIT_LOCK: 40 high, 1 low, then high
    count_until(0, 1'b0, 100, n);
    chk("glitch_reset_cycles", n, 16);
    #1 pll_lock = 1'b1;
    repeat (40) @(posedge clk);
    #2 pll_lock = 1'b0;
    @(posedge clk);
    #2 pll_lock = 1'b1;
    count_until(1, 1'b1, 300, n);
    chk("glitch_lock_latency", n, 66);

    // Lock loss in IDLE: automatic relock with unchanged dividers
    #1 pll_lock = 1'b0;
    count_until(1, 1'b0, 20, n);
    chk("loss_latency", n, 3);
    chk("loss_pll_reset", int'(pll_reset), 1);
    chk("loss_fdiv", int'(fdiv), int'(6'b111000));
    chk("loss_idiv", int'(idiv), int'(6'b111101));

    // Lock never returns: retries then ERROR
    pulses   = 1;
    seq      = 0;
    prev_rst = pll_reset;
    prev_rty = retry_cnt;
    for (int i = 0; (i < 3000) && !err; i++) begin
      @(posedge clk);
      #1;
      if (pll_reset && !prev_rst) pulses++;
      prev_rst = pll_reset;
      if (retry_cnt != prev_rty) begin
        seq      = seq * 10 + int'(retry_cnt);
        prev_rty = retry_cnt;
      end
    end
    chk("timeout_pulses", pulses, 4);
    chk("timeout_retry_seq", seq, 123);
    chk("error_err", int'(err), 1);
    chk("error_ready", int'(req_ready), 1);
    chk("error_busy", int'(busy), 0);
    chk("error_pll_reset", int'(pll_reset), 0);
    chk("error_retry", int'(retry_cnt), 3);

    // New request clears the error
    #1;
    req_valid = 1'b1;
    req_fdiv  = 6'd20;
    req_idiv  = 6'd3;
    @(posedge clk);
    #1;
    chk("clear_err", int'(err), 0);
    chk("clear_retry", int'(retry_cnt), 0);
    chk("clear_pll_reset", int'(pll_reset), 1);
    chk("clear_fdiv", int'(fdiv), int'(6'b101011));
    #1 req_valid = 1'b0;

    // Asynchronous reset while in WAIT_LOCK
    count_until(0, 1'b0, 100, n);
    chk("mid_reset_cycles", n, 16);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_pll_reset", int'(pll_reset), 1);
    chk("async_fdiv", int'(fdiv), int'(6'b110011));
    chk("async_idiv", int'(idiv), int'(6'b111010));
    chk("async_busy", int'(busy), 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    pll_lock = 1'b1;
    count_until(1, 1'b1, 300, n);
    chk("repwr_lock_latency", n, 80);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    fork
      compare_loop();
      main_seq();
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Control stage directly upstream of the Gowin PLLVR dynamic-divider wrapper.
- Drives the PLL's RESET, FBDSEL (fdiv) and IDSEL (idiv) inputs and consumes its LOCK output.
- Accepts divider-change requests over a valid/ready handshake and sequences each change as: hold PLL in reset, release, wait for stable lock, with timeout-driven retries.
- Runs on the fixed reference clock, the same clock that feeds the PLL CLKIN.

Parameters:
- INIT_FDIV, 12, feedback divider value (FBDIV_SEL) applied at power-up.
- INIT_IDIV, 5, input divider value (IDIV_SEL) applied at power-up.
- RESET_CYCLES, 16, number of cycles pll_reset is held high per attempt; must be >= 1.
- LOCK_STABLE, 64, consecutive synchronised-lock-high cycles required to declare lock; must be >= 1.
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before an attempt fails.
- MAX_RETRY, 3, number of extra attempts after the first failure before entering ERROR.

Ports:
- clk  in  1  reference clock; the single clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  new divider request is present.
- req_ready  out  1  block can accept a request this cycle.
- req_fdiv  in  6  requested FBDIV_SEL value (natural encoding).
- req_idiv  in  6  requested IDIV_SEL value (natural encoding).
- pll_lock  in  1  PLL LOCK output; asynchronous to clk.
- pll_reset  out  1  drives the PLL RESET input.
- fdiv  out  6  drives FBDSEL; inverted encoding, fdiv = ~value.
- idiv  out  6  drives IDSEL; inverted encoding, idiv = ~value.
- locked  out  1  PLL is locked at the currently applied divider values.
- busy  out  1  a reconfiguration or relock sequence is in progress.
- err  out  1  retries are exhausted; sticky until a new request is accepted or reset.
- retry_cnt  out  clog2(MAX_RETRY+1)  number of retries used in the current sequence.

Behaviour:
- Reset (rst_n low), applied asynchronously:
  - State = RESET; pll_reset = 1.
  - fdiv = ~INIT_FDIV; idiv = ~INIT_IDIV.
  - locked = 0; err = 0; req_ready = 0; busy = 1; retry_cnt = 0.
  - All counters = 0; lock synchroniser flops = 0.
- When rst_n releases, the FSM runs the power-up lock sequence starting in RESET.
- Lock synchroniser: pll_lock passes through a 2-flop synchroniser to give lock_s. This adds 2 cycles of latency.
- FSM states: RESET, WAIT_LOCK, IDLE, ERROR. All outputs are registered.
- RESET:
  - pll_reset = 1; busy = 1.
  - Stays exactly RESET_CYCLES cycles, then moves to WAIT_LOCK.
  - The stable and timeout counters are cleared on entry to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset = 0.
  - Stable counter increments while lock_s = 1 and clears to 0 on any lock_s = 0.
  - Timeout counter increments every cycle.
  - When the stable count reaches LOCK_STABLE: go to IDLE, set locked = 1, clear retry_cnt.
  - If the timeout count reaches LOCK_TIMEOUT-1 first and retry_cnt < MAX_RETRY: increment retry_cnt and go to RESET.
  - If the timeout count reaches LOCK_TIMEOUT-1 first and retry_cnt = MAX_RETRY: go to ERROR, set err = 1.
  - If stable-done and timeout occur in the same cycle, lock wins.
- IDLE:
  - req_ready = 1; busy = 0; locked = 1.
  - If lock_s falls with no request: locked = 0 next cycle, go to RESET (automatic relock with the same values), retry_cnt = 0.
- ERROR:
  - req_ready = 1; busy = 0; locked = 0; err = 1.
  - pll_reset = 0; the divider values are held.
- Handshake:
  - A request is accepted on a rising clk edge when req_valid && req_ready.
  - In that same edge: fdiv <= ~req_fdiv, idiv <= ~req_idiv, err <= 0, retry_cnt <= 0, locked <= 0, state <= RESET.
  - So pll_reset = 1 from the first cycle after acceptance.
  - Divider outputs change only on acceptance or reset, never while pll_reset = 0 in WAIT_LOCK.
- Simultaneous accepted request and lock loss in IDLE: the request wins, and the new values are applied.
- req_ready = 0 in RESET and WAIT_LOCK. Requests presented there stall; no request is dropped or queued.
- Counters saturate and never wrap. Counter widths are clog2 of the respective parameter.
- Reset asserted mid-sequence: immediate return to reset values. Any in-flight request values are discarded, and the INIT values are reapplied.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - the state enum (RESET, WAIT_LOCK, IDLE, ERROR);
  - a function for the divider encoding (bitwise invert);
  - width localparams derived from the parameters.
- One sub-module: sync2, a 2-flop synchroniser with async active-low reset to 0, used for pll_lock.
- The FSM and counters stay in pll_reconfig_ctrl.

Test Plan:
- Power-up:
  - Stimulus: release rst_n; pll_lock rises 100 cycles later and stays high.
  - Required: pll_reset = 1 for 16 cycles; fdiv = 6'b110011 (~12); idiv = 6'b111010 (~5); locked = 1 exactly 2+64 cycles after pll_lock rises; req_ready = 1.
- Reconfiguration:
  - Stimulus: in IDLE, request fdiv = 20, idiv = 3.
  - Required: next cycle fdiv = 6'b101011, idiv = 6'b111100, pll_reset = 1, locked = 0, req_ready = 0; relock follows when the lock is stable.
- Lock glitch:
  - Stimulus: in WAIT_LOCK, pll_lock high 40 cycles, low 1 cycle, then high.
  - Required: the stable counter restarts; locked is asserted 64 cycles after the second rise plus sync latency.
- Timeout and retries:
  - Stimulus: pll_lock held at 0 (use LOCK_TIMEOUT = 256 for speed).
  - Required: 4 RESET pulses total, retry_cnt steps 1, 2, 3, then ERROR with err = 1 and req_ready = 1; a new request then clears err.
- Lock loss in IDLE:
  - Stimulus: drop pll_lock.
  - Required: locked = 0 three cycles later and an automatic RESET pulse, with fdiv and idiv unchanged. A request and lock loss in the same cycle must apply the new values.
- Reset mid-sequence:
  - Stimulus: assert rst_n low during WAIT_LOCK after a request for fdiv = 20.
  - Required: pll_reset = 1 and fdiv = ~12 asynchronously, with no clk edge needed.
